// File: rtl/uart_frame_receiver.sv
// UART frame receiver: 2-flop synchronized rx, mid-bit sampling FSM, receive FIFO.
// Ports: clk, reset (sync, active-high), uart_rx in; data/valid/ready head
// handshake; frame_err/parity_err per head entry; overrun sticky; busy.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_frame_receiver #(
  parameter int CLKS_PER_BIT = 10000,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state, state_nx;

  logic rx_meta, rx_sync;
  logic [CW-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic push;
  logic perr_new;
  logic [EW-1:0] entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_nx;

  always_ff @(posedge clk) begin
    if (reset) par_bit <= 1'b0;
    else       par_bit <= par_bit_nx;
  end

  assign perr_new = ((^shreg) ^ par_bit) != PARITY_ODD;
`else
  logic unused_par;
  assign unused_par = PARITY_ODD;
  assign perr_new   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      clk_cnt <= clk_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clk_cnt_nx = clk_cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    push       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nx = par_bit;
`endif
    unique case (state)
      IDLE: begin
        clk_cnt_nx = '0;
        if (!rx_sync) state_nx = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nx = '0;
          bit_cnt_nx = '0;
          // line back high at mid start bit: treat as glitch
          state_nx   = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_FULL) begin
          clk_cnt_nx        = '0;
          shreg_nx[bit_cnt] = rx_sync;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == CNT_FULL) begin
          clk_cnt_nx = '0;
          par_bit_nx = rx_sync;
          state_nx   = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == CNT_FULL) begin
          // leave at mid-stop so the next start edge is not missed
          clk_cnt_nx = '0;
          push       = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign entry = {perr_new, !rx_sync, shreg};

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic empty, full, pop, wr_en, drop;
  logic [EW-1:0] head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (drop)     overrun <= 1'b1;
      else if (pop) overrun <= 1'b0;
    end
  end

  assign head       = mem[rptr[AW-1:0]];
  assign valid      = !empty;
  assign data       = valid ? head[DATA_BITS-1:0] : '0;
  assign frame_err  = valid ? head[DATA_BITS] : 1'b0;
  assign parity_err = valid ? head[DATA_BITS+1] : 1'b0;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver (16 clks/bit, 8 data bits, 4-deep FIFO).
// Expected entries are hand-computed; popped entries are logged by a monitor.
module tb_uart_frame_receiver;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun, busy;

  int vec = 0;
  int errs = 0;
  int valid_cycles = 0;
  logic [9:0] rxq[$];

  uart_frame_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .FIFO_DEPTH(4),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // pop log: values seen at the edge that performs the pop
  always @(posedge clk) begin
    if (valid) valid_cycles <= valid_cycles + 1;
    if (valid && ready && !reset) rxq.push_back({parity_err, frame_err, data});
  end

  function automatic logic [9:0] get_entry(input int idx);
    if (idx < rxq.size()) return rxq[idx];
    return 10'bx;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic par);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (HAS_PAR) begin
      uart_rx = par;
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    vec++; if (valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", valid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL rst_overrun got %b want 0", overrun); end
    vec++; if (data !== 8'h00) begin errs++; $display("FAIL rst_data got %h want 00", data); end
    vec++; if (frame_err !== 1'b0) begin errs++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    vec++; if (parity_err !== 1'b0) begin errs++; $display("FAIL rst_perr got %b want 0", parity_err); end
  endtask

  task automatic test_basic();
    int q0, v0;
    logic [9:0] e;
    q0 = rxq.size(); v0 = valid_cycles;
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    e = get_entry(q0);
    vec++; if (valid_cycles - v0 !== 1) begin errs++; $display("FAIL basic_valid_cycles got %0d want 1", valid_cycles - v0); end
    vec++; if (rxq.size() - q0 !== 1) begin errs++; $display("FAIL basic_pops got %0d want 1", rxq.size() - q0); end
    vec++; if (e[7:0] !== 8'hA5) begin errs++; $display("FAIL basic_data got %h want a5", e[7:0]); end
    vec++; if (e[8] !== 1'b0) begin errs++; $display("FAIL basic_ferr got %b want 0", e[8]); end
    vec++; if (e[9] !== 1'b0) begin errs++; $display("FAIL basic_perr got %b want 0", e[9]); end
  endtask

  task automatic test_glitch();
    int v0, n;
    v0 = valid_cycles;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL glitch_busy_high got %b want 1", busy); end
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL glitch_busy_low got %b want 0 after %0d cycles", busy, n); end
    repeat (2 * CPB) @(negedge clk);
    vec++; if (valid_cycles - v0 !== 0) begin errs++; $display("FAIL glitch_valid got %0d cycles want 0", valid_cycles - v0); end
  endtask

  task automatic test_frame_err();
    int q0;
    logic [9:0] e0, e1;
    q0 = rxq.size();
    ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    e0 = get_entry(q0);
    e1 = get_entry(q0 + 1);
    vec++; if (rxq.size() - q0 !== 2) begin errs++; $display("FAIL ferr_pops got %0d want 2", rxq.size() - q0); end
    vec++; if (e0[8:0] !== {1'b1, 8'h3C}) begin errs++; $display("FAIL ferr_entry got %h want 13c", e0[8:0]); end
    vec++; if (e1[8:0] !== {1'b0, 8'h55}) begin errs++; $display("FAIL ferr_next got %h want 055", e1[8:0]); end
  endtask

  task automatic test_overrun();
    int q0;
    logic [9:0] e;
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    q0 = rxq.size();
    vec++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_set got %b want 1", overrun); end
    vec++; if (valid !== 1'b1) begin errs++; $display("FAIL ovr_valid got %b want 1", valid); end
    vec++; if (data !== 8'h01) begin errs++; $display("FAIL ovr_head got %h want 01", data); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_clear got %b want 0", overrun); end
    vec++; if (data !== 8'h02) begin errs++; $display("FAIL ovr_head2 got %h want 02", data); end
    ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    vec++; if (valid !== 1'b0) begin errs++; $display("FAIL ovr_drained got %b want 0", valid); end
    vec++; if (rxq.size() - q0 !== 4) begin errs++; $display("FAIL ovr_pops got %0d want 4", rxq.size() - q0); end
    for (int i = 0; i < 4; i++) begin
      e = get_entry(q0 + i);
      vec++; if (e[7:0] !== 8'(i + 1)) begin errs++; $display("FAIL ovr_pop%0d got %h want %h", i, e[7:0], 8'(i + 1)); end
    end
  endtask

  task automatic test_parity();
    int q0;
    logic [9:0] e0, e1;
    q0 = rxq.size();
    ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    e0 = get_entry(q0);
    e1 = get_entry(q0 + 1);
    vec++; if (e0 !== {HAS_PAR, 1'b0, 8'h07}) begin errs++; $display("FAIL par0_entry got %h want %h", e0, {HAS_PAR, 1'b0, 8'h07}); end
    vec++; if (e1 !== {1'b0, 1'b0, 8'h07}) begin errs++; $display("FAIL par1_entry got %h want 007", e1); end
  endtask

  task automatic test_reset_mid_frame();
    int q0;
    logic [9:0] e;
    q0 = rxq.size();
    ready = 1'b1;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_busy got %b want 1", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    vec++; if (valid !== 1'b0) begin errs++; $display("FAIL rmid_valid got %b want 0", valid); end
    vec++; if (rxq.size() - q0 !== 0) begin errs++; $display("FAIL rmid_pops got %0d want 0", rxq.size() - q0); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_idle got %b want 0", busy); end
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    e = get_entry(q0);
    vec++; if (e !== {2'b00, 8'hC3}) begin errs++; $display("FAIL rmid_next got %h want 0c3", e); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_parity();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
